// File: rtl/wb_pkg.sv
// wb_pkg: shared encodings, FSM states and defaults for the Wishbone master bridge.
package wb_pkg;
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_ILLEGAL = 2'b11;
  localparam int TIMEOUT_DEFAULT = 16;
  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    return size == SIZE_ILLEGAL || (size == SIZE_HALF && off[0]) || (size == SIZE_WORD && off != 2'b00);
  endfunction
endpackage

// File: rtl/wb_lane_align.sv
// wb_lane_align: byte selects, lane-replicated write data and right-aligned, masked read data.
module wb_lane_align
  import wb_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] bus_rdata,
  output logic [3:0]  sel,
  output logic [31:0] wdat,
  output logic [31:0] rdata
);
  logic [31:0] shifted;
  always_comb begin
    shifted = bus_rdata >> {off, 3'b000};
    sel = size == SIZE_BYTE ? 4'b0001 << off : size == SIZE_HALF ? 4'b0011 << off : 4'b1111;
    wdat = size == SIZE_BYTE ? {4{wdata[7:0]}} : size == SIZE_HALF ? {2{wdata[15:0]}} : wdata;
    rdata = size == SIZE_BYTE ? {24'h0, shifted[7:0]} : size == SIZE_HALF ? {16'h0, shifted[15:0]} : shifted;
  end
endmodule

// File: rtl/wishbone_master_bridge.sv
// wishbone_master_bridge: one core load/store request -> one Wishbone classic cycle -> one response pulse.
module wishbone_master_bridge
  import wb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [1:0]        req_size_i,
  input  logic [31:0]       req_wdata_i,
  output logic              rsp_valid_o,
  output logic [31:0]       rsp_rdata_o,
  output logic              rsp_err_o,
  output logic [ADDR_W-1:0] adr_o,
  output logic [31:0]       dat_o,
  input  logic [31:0]       dat_i,
  output logic              we_o,
  output logic [3:0]        sel_o,
  output logic              stb_o,
  output logic              cyc_o,
  input  logic              ack_i,
  input  logic              err_i
);
  localparam int CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  state_t state, next;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0] size_q;
  logic we_q, err_q, bus, bad, timeout;
  logic [31:0] wdata_q, rdata_q, wdat, rdata_al;
  logic [3:0] sel;
  logic [CW-1:0] cnt;
  wb_lane_align u_align (
    .size(size_q), .off(addr_q[1:0]), .wdata(wdata_q), .bus_rdata(dat_i),
    .sel(sel), .wdat(wdat), .rdata(rdata_al)
  );
  assign bus = state == BUS;
  assign bad = misaligned(req_size_i, req_addr_i[1:0]);
  assign timeout = TIMEOUT_CYCLES > 0 && cnt == CW'(TIMEOUT_CYCLES - 1);
  assign req_ready_o = state == IDLE;
  assign cyc_o = bus;
  assign stb_o = bus;
  assign we_o = bus & we_q;
  assign adr_o = bus ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign sel_o = bus ? sel : '0;
  assign dat_o = bus ? wdat : '0;
  assign rsp_valid_o = state == RESP;
  assign rsp_err_o = rsp_valid_o & err_q;
  assign rsp_rdata_o = rsp_valid_o ? rdata_q : '0;
  always_comb begin
    next = IDLE;
    if (state == IDLE) next = !req_valid_i ? IDLE : bad ? RESP : BUS;
    else if (bus) next = ack_i || err_i || timeout ? RESP : BUS;
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) state <= IDLE;
    else state <= next;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q <= '0;
      size_q <= '0;
      we_q <= 1'b0;
      wdata_q <= '0;
      err_q <= 1'b0;
      rdata_q <= '0;
      cnt <= '0;
    end else if (state == IDLE && req_valid_i) begin
      addr_q <= req_addr_i;
      size_q <= req_size_i;
      we_q <= req_we_i;
      wdata_q <= req_wdata_i;
      err_q <= bad;
      rdata_q <= '0;
      cnt <= '0;
    end else if (bus) begin
      cnt <= cnt + CW'(~&cnt);
      // err beats ack; a same-cycle ack beats the watchdog
      if (err_i || (timeout && !ack_i)) err_q <= 1'b1;
      else if (ack_i && !we_q) rdata_q <= rdata_al;
    end
  end
endmodule

// File: tb/tb_wishbone_master_bridge.sv
// tb_wishbone_master_bridge: randomized transfers against a byte-lane reference model plus directed corner cases.
module tb_wishbone_master_bridge;
  logic clk = 0, rst = 1;
  logic req_valid = 0, req_ready, req_we = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic [1:0] req_size = 0;
  logic rsp_valid, rsp_err;
  logic [31:0] rsp_rdata, adr, dat_o, dat_i = 0;
  logic we, stb, cyc, ack = 0, err = 0;
  logic [3:0] sel;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  wishbone_master_bridge dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_we_i(req_we), .req_addr_i(req_addr), .req_size_i(req_size), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .adr_o(adr), .dat_o(dat_o), .dat_i(dat_i), .we_o(we), .sel_o(sel),
    .stb_o(stb), .cyc_o(cyc), .ack_i(ack), .err_i(err)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // mode: 0 ack, 1 err, 2 ack+err, 3 silent slave; lat = stb cycle in which the slave responds
  task automatic xfer(input logic w, input logic [1:0] size, input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] rd, input int lat, input int mode);
    int off, n, cycles, samp, estb;
    logic bad, eerr, done;
    logic [3:0] esel;
    logic [31:0] edat, erd;
    off = int'(a[1:0]);
    n = size == 2'd0 ? 1 : size == 2'd1 ? 2 : 4;
    bad = size == 2'd3 || off % n != 0;
    for (int i = 0; i < 4; i++) begin
      esel[i] = i >= off && i < off + n;
      edat[8*i +: 8] = wd[8*(i % n) +: 8];
    end
    estb = bad ? 0 : mode == 3 ? 16 : lat;
    eerr = bad || mode != 0;
    erd = 0;
    if (!bad && !w && mode == 0)
      for (int i = 0; i < n; i++) erd[8*i +: 8] = rd[8*(off + i) +: 8];
    @(negedge clk);
    check("ready_before", {31'b0, req_ready}, 1);
    req_valid = 1; req_we = w; req_size = size; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 0;
    cycles = 0; samp = 0; done = 0;
    while (!done && samp < 40) begin
      @(negedge clk);
      samp++;
      if (stb) begin
        cycles++;
        check("sel", {28'b0, sel}, {28'b0, esel});
        check("adr", adr, a & 32'hFFFF_FFFC);
        if (cycles == 1) begin
          check("dat_o", dat_o, edat);
          check("we", {31'b0, we}, {31'b0, w});
          check("cyc", {31'b0, cyc}, 1);
        end
        ack = (mode == 0 || mode == 2) && cycles == lat;
        err = (mode == 1 || mode == 2) && cycles == lat;
        dat_i = rd;
      end else begin
        ack = 0; err = 0;
      end
      if (rsp_valid) begin
        done = 1;
        check("stb_cycles", cycles, estb);
        check("rsp_latency", samp, estb + 1);
        check("rsp_err", {31'b0, rsp_err}, {31'b0, eerr});
        check("rsp_rdata", rsp_rdata, erd);
        check("idle_bus_at_rsp", {31'b0, stb | cyc}, 0);
      end
    end
    if (!done) check("rsp_timeout", 0, 1);
    ack = 0; err = 0;
    @(negedge clk);
    check("rsp_pulse", {31'b0, rsp_valid}, 0);
    check("ready_after", {31'b0, req_ready}, 1);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    check("rst_ready", {31'b0, req_ready}, 1);
    check("rst_stb", {31'b0, stb | cyc}, 0);
    check("rst_rsp", {31'b0, rsp_valid}, 0);
    check("rst_outs", adr | dat_o | {28'b0, sel} | {31'b0, we}, 0);
    rst = 0;
    xfer(1, 2'd2, 32'h1004, 32'hDEADBEEF, 32'h0, 2, 0);
    xfer(0, 2'd0, 32'h2003, 32'h0, 32'hAB000000, 2, 0);
    xfer(0, 2'd1, 32'h3001, 32'h0, 32'h0, 2, 0);
    xfer(0, 2'd3, 32'h3000, 32'h0, 32'h0, 2, 0);
    xfer(0, 2'd2, 32'h4000, 32'h0, 32'h12345678, 1, 3);
    xfer(0, 2'd1, 32'h5002, 32'h0, 32'hCAFEF00D, 3, 2);
    xfer(1, 2'd1, 32'h5006, 32'h0000BEEF, 32'h0, 1, 1);
    @(negedge clk);
    ack = 1; err = 1;
    repeat (3) begin
      @(negedge clk);
      check("stray_no_rsp", {31'b0, rsp_valid}, 0);
      check("stray_no_stb", {31'b0, stb}, 0);
    end
    ack = 0; err = 0;
    @(negedge clk);
    req_valid = 1; req_we = 0; req_size = 2'd2; req_addr = 32'h6000;
    @(posedge clk);
    #1 req_valid = 0;
    @(negedge clk);
    check("pre_rst_stb", {31'b0, stb}, 1);
    rst = 1;
    #1;
    check("mid_rst_stb", {31'b0, stb | cyc}, 0);
    check("mid_rst_ready", {31'b0, req_ready}, 1);
    check("mid_rst_rsp", {31'b0, rsp_valid}, 0);
    @(negedge clk);
    rst = 0;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_no_rsp", {31'b0, rsp_valid | stb}, 0);
    end
    for (int t = 0; t < 60; t++) begin
      int r;
      r = int'($urandom_range(0, 9));
      xfer(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, $urandom, $urandom,
           int'($urandom_range(1, 4)), r < 6 ? 0 : r == 6 ? 1 : r == 7 ? 2 : 3);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
